// File: rtl/tag_frame_buff.sv
// Frame-aware tag data buffer: AXI-Stream frames are stored behind a header word
// and serialized READ_WIDTH bits at a time to the MCU over the EBI strobe interface.
module tag_frame_buff #(
  parameter int    NUM_TAGS      = 10,
  parameter int    NUM_CHANNELS  = 4,
  parameter int    CHANNEL_WIDTH = 64,
  parameter int    FIFO_DEPTH    = 128,
  parameter int    READ_WIDTH    = 16,
  parameter string MEMORY_TYPE   = "block"
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_TAGS-1:0]                   s_axis_tuser,
  input  logic                                  s_axis_tlast,
  input  logic                                  flush,
  input  logic                                  rd_ena,
  output logic                                  rd_ready,
  output logic [READ_WIDTH-1:0]                 rd_data,
  output logic [$clog2(FIFO_DEPTH):0]           frames_avail,
  output logic [15:0]                           drop_cnt
);

  localparam int DATA_WIDTH = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;
  localparam int NSLICE     = DATA_WIDTH / READ_WIDTH;
  localparam int SW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_HDR, S_DROP} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         tent_ptr_q, tent_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]         slice_q, slice_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_TAGS-1:0]   tuser_q, tuser_d;
  logic [PW-1:0]         frames_q, frames_d;
  logic [15:0]           drop_q, drop_d;
  logic                  silent_q, silent_d;
  logic                  alive_q;
  logic                  rd_ena_q;
  logic [READ_WIDTH-1:0] rd_data_q;

  logic                  accept, in_frame, commit, drop_inc;
  logic                  mem_we, mem_wlast;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [PW-1:0]         fill_first, fill_next;
  logic                  fits_first, fits_next;
  logic                  consume, last_slice, frame_done;

  logic [DATA_WIDTH-1:0] mem      [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  word_valid;
  logic [NSLICE-1:0][READ_WIDTH-1:0] rd_slices;

  assign s_axis_tready = alive_q && (state_q != S_HDR);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign rd_ready      = (rd_ptr_q != wr_ptr_q);
  assign rd_data       = rd_data_q;
  assign frames_avail  = frames_q;
  assign drop_cnt      = drop_q;

  // Occupancy (entries past the read pointer) after the next write; modulo pointer arithmetic.
  assign fill_first = wr_ptr_q + PW'(2) - rd_ptr_q;
  assign fill_next  = tent_ptr_q + PW'(1) - rd_ptr_q;
  assign fits_first = (fill_first <= DEPTH_P);
  assign fits_next  = (fill_next <= DEPTH_P);
  assign in_frame   = (state_q == S_DATA) || (state_q == S_DROP) || ((state_q == S_IDLE) && accept);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    tent_ptr_d = tent_ptr_q;
    beat_cnt_d = beat_cnt_q;
    tuser_d    = tuser_q;
    silent_d   = silent_q;
    mem_we     = 1'b0;
    mem_waddr  = tent_ptr_q[AW-1:0];
    mem_wdata  = s_axis_tdata;
    mem_wlast  = s_axis_tlast;
    commit     = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        beat_cnt_d = 16'd1;
        if (s_axis_tlast) tuser_d = s_axis_tuser;
        if (fits_first) begin
          mem_we     = 1'b1;
          mem_waddr  = wr_ptr_q[AW-1:0] + AW'(1);
          tent_ptr_d = wr_ptr_q + PW'(2);
          state_d    = s_axis_tlast ? S_HDR : S_DATA;
        end else begin
          silent_d = 1'b0;
          if (s_axis_tlast) drop_inc = 1'b1;
          else              state_d  = S_DROP;
        end
      end
      S_DATA: if (accept) begin
        if (s_axis_tlast) tuser_d = s_axis_tuser;
        if (fits_next) begin
          mem_we     = 1'b1;
          tent_ptr_d = tent_ptr_q + PW'(1);
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (s_axis_tlast) state_d = S_HDR;
        end else begin
          tent_ptr_d = wr_ptr_q;
          silent_d   = 1'b0;
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DROP;
          end
        end
      end
      S_HDR: begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q[AW-1:0];
        mem_wdata = '0;
        mem_wdata[NUM_TAGS+15:0] = {tuser_q, beat_cnt_q};
        mem_wlast = 1'b0;
        wr_ptr_d  = tent_ptr_q;
        commit    = 1'b1;
        state_d   = S_IDLE;
      end
      S_DROP: if (accept && s_axis_tlast) begin
        tent_ptr_d = wr_ptr_q;
        drop_inc   = !silent_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush abandons everything; an interrupted frame drains its tail without counting as a drop.
    if (flush) begin
      wr_ptr_d   = '0;
      tent_ptr_d = '0;
      mem_we     = 1'b0;
      commit     = 1'b0;
      if (in_frame && !(accept && s_axis_tlast)) begin
        state_d  = S_DROP;
        silent_d = 1'b1;
      end else begin
        state_d  = S_IDLE;
      end
    end
  end

  assign consume    = rd_ena && !rd_ena_q && rd_ready && !flush;
  assign last_slice = (slice_q == SW'(NSLICE - 1));
  assign frame_done = consume && last_slice && last_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    slice_d  = slice_q;
    frames_d = frames_q;
    drop_d   = drop_q;
    if (consume) begin
      if (last_slice) begin
        slice_d  = '0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        slice_d  = slice_q + SW'(1);
      end
    end
    if (commit && !frame_done)      frames_d = frames_q + PW'(1);
    else if (!commit && frame_done) frames_d = frames_q - PW'(1);
    if (flush) begin
      rd_ptr_d = '0;
      slice_d  = '0;
      frames_d = '0;
    end
    if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      tent_ptr_q <= '0;
      rd_ptr_q   <= '0;
      slice_q    <= '0;
      beat_cnt_q <= '0;
      tuser_q    <= '0;
      frames_q   <= '0;
      drop_q     <= '0;
      silent_q   <= 1'b0;
      alive_q    <= 1'b0;
      rd_ena_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      tent_ptr_q <= tent_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      slice_q    <= slice_d;
      beat_cnt_q <= beat_cnt_d;
      tuser_q    <= tuser_d;
      frames_q   <= frames_d;
      drop_q     <= drop_d;
      silent_q   <= silent_d;
      alive_q    <= 1'b1;
      rd_ena_q   <= rd_ena;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr]      <= mem_wdata;
      last_mem[mem_waddr] <= mem_wlast;
    end
  end

  // Block RAM needs a registered read port; the valid flag follows the same pipeline stage.
  if (MEMORY_TYPE == "block") begin : g_block_rd
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic                  word_valid_q;
    always_ff @(posedge clk) begin
      rd_word_q <= mem[rd_ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) word_valid_q <= 1'b0;
      else        word_valid_q <= rd_ready && !flush;
    end
    assign rd_word    = rd_word_q;
    assign word_valid = word_valid_q;
  end else begin : g_dist_rd
    assign rd_word    = mem[rd_ptr_q[AW-1:0]];
    assign word_valid = rd_ready;
  end

  assign rd_slices = rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rd_data_q <= '0;
    else if (word_valid) rd_data_q <= rd_slices[slice_q];
  end

endmodule
